// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the 8-bit combinational ALU: accepts one command,
// drives registered operands for a settle cycle, then holds the captured response.
//
// state | meaning
// IDLE  | ready for a command (cmd_ready = 1)
// ISSUE | operands on the ALU, result captured at the end of this cycle
// RESP  | response held on rsp_* until rsp_ready
module alu_cmd_sequencer #(
  parameter int               WIDTH    = 8,
  parameter int               COUNT_W  = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_opcode,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic               cmd_use_acc,
  input  logic               cmd_wr_acc,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_opcode,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  input  logic               alu_sign,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [3:0]         rsp_flags,
  output logic [WIDTH-1:0]   acc,
  output logic               sticky_ovf,
  output logic               sticky_div0,
  input  logic               clr_sticky,
  output logic [COUNT_W-1:0] op_count,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  logic   wr_acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      wr_acc_q    <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      acc         <= ACC_INIT;
      sticky_ovf  <= 1'b0;
      sticky_div0 <= 1'b0;
      op_count    <= '0;
    end else begin
      // Clear first so a set event in the same cycle overrides it below.
      if (clr_sticky) begin
        sticky_ovf  <= 1'b0;
        sticky_div0 <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a      <= cmd_use_acc ? acc : cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_opcode;
            wr_acc_q   <= cmd_wr_acc;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_sign, alu_overflow, alu_zero, alu_carry};
          if (wr_acc_q) acc <= alu_result;
          if (alu_overflow) sticky_ovf <= 1'b1;
          if ((alu_opcode == 4'hE) && (alu_b == '0)) sticky_div0 <= 1'b1;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            op_count  <= op_count + COUNT_W'(1);
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural ALU closes the loop, directed
// vectors with hand-computed results, plus reset and sticky-clear sequences.
module tb_alu_cmd_sequencer;

  localparam logic [7:0] ACC_RST = 8'h5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [7:0]  cmd_a, cmd_b;
  logic        cmd_use_acc, cmd_wr_acc;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        alu_carry, alu_zero, alu_overflow, alu_sign;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_flags;
  logic [7:0]  acc;
  logic        sticky_ovf, sticky_div0, clr_sticky;
  logic [15:0] op_count;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(8), .COUNT_W(16), .ACC_INIT(ACC_RST)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .acc(acc), .sticky_ovf(sticky_ovf),
    .sticky_div0(sticky_div0), .clr_sticky(clr_sticky), .op_count(op_count),
    .busy(busy)
  );

  // Behavioural ALU: 0 ADD, 1 SUB, 6 INC, D MUL, E DIV, others return 0.
  logic [8:0]  t9;
  logic [15:0] prod;
  always_comb begin
    t9 = '0;
    prod = '0;
    alu_result = '0;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      4'h0: begin
        t9 = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = t9[7:0];
        alu_carry = t9[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (t9[7] != alu_a[7]);
      end
      4'h1: begin
        t9 = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = t9[7:0];
        alu_carry = t9[8];
        alu_overflow = (alu_a[7] != alu_b[7]) && (t9[7] != alu_a[7]);
      end
      4'h6: begin
        t9 = {1'b0, alu_a} + 9'd1;
        alu_result = t9[7:0];
        alu_carry = t9[8];
        alu_overflow = (alu_a == 8'h7F);
      end
      4'hD: begin
        prod = alu_a * alu_b;
        alu_result = prod[7:0];
        alu_carry = |prod[15:8];
        alu_overflow = |prod[15:8];
      end
      4'hE: begin
        if (alu_b == 8'h00) begin
          alu_result = 8'hFF;
          alu_carry = 1'b1;
        end else begin
          alu_result = alu_a / alu_b;
        end
      end
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
    alu_sign = alu_result[7];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    logic       ua, wa, clr;
    int         hold;
    logic [7:0] e_alu_a, e_res;
    logic [3:0] e_flags;
    logic [7:0] e_acc;
    logic       e_ovf, e_div;
  } vec_t;

  vec_t vecs[9];

  initial begin
    //          op     a      b      ua    wa    clr  hold alu_a  res    flags    acc    ovf   div
    vecs[0] = '{4'h0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 0, 8'h7F, 8'h80, 4'b1100, ACC_RST, 1'b1, 1'b0};
    vecs[1] = '{4'h1, 8'h05, 8'h05, 1'b0, 1'b1, 1'b0, 5, 8'h05, 8'h00, 4'b0010, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{4'hE, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h10, 8'hFF, 4'b1001, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{4'h0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 0, 8'hFF, 8'hFF, 4'b1000, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{4'h6, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'hFF, 8'h00, 4'b0011, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{4'hE, 8'h10, 8'h03, 1'b0, 1'b0, 1'b0, 0, 8'h10, 8'h05, 4'b0000, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{4'hF, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 0, 8'h12, 8'h00, 4'b0010, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{4'hD, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 0, 8'h10, 8'h00, 4'b0111, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{4'h0, 8'h00, 8'h02, 1'b1, 1'b1, 1'b0, 0, 8'hFF, 8'h01, 4'b0001, 8'h01, 1'b1, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; cmd_wr_acc = 1'b0; rsp_ready = 1'b0; clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc, ACC_RST);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_sticky", {sticky_ovf, sticky_div0}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      logic [7:0] held;
      if (vecs[i].clr) begin
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
      end
      @(negedge clk);
      cmd_opcode = vecs[i].op; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
      cmd_use_acc = vecs[i].ua; cmd_wr_acc = vecs[i].wa; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk($sformatf("v%0d_issue_busy", i), busy, 1);
      chk($sformatf("v%0d_issue_ready", i), cmd_ready, 0);
      chk($sformatf("v%0d_issue_rspv", i), rsp_valid, 0);
      chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].e_alu_a);
      chk($sformatf("v%0d_alu_b_op", i), {alu_b, alu_opcode}, {vecs[i].b, vecs[i].op});
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_rsp_result", i), rsp_result, vecs[i].e_res);
      chk($sformatf("v%0d_rsp_flags", i), rsp_flags, vecs[i].e_flags);
      chk($sformatf("v%0d_acc", i), acc, vecs[i].e_acc);
      chk($sformatf("v%0d_sticky", i), {sticky_ovf, sticky_div0}, {vecs[i].e_ovf, vecs[i].e_div});
      held = rsp_result;
      for (int h = 0; h < vecs[i].hold; h++) begin
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d_stall%0d_valid", i, h), rsp_valid, 1);
        chk($sformatf("v%0d_stall%0d_data", i, h), {rsp_result, rsp_flags}, {held, vecs[i].e_flags});
        chk($sformatf("v%0d_stall%0d_ready", i, h), cmd_ready, 0);
        chk($sformatf("v%0d_stall%0d_count", i, h), op_count, exp_cnt);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      exp_cnt++;
      chk($sformatf("v%0d_done_count", i), op_count, exp_cnt);
      chk($sformatf("v%0d_done_valid", i), rsp_valid, 0);
      chk($sformatf("v%0d_done_ready", i), cmd_ready, 1);
    end

    // clr_sticky held across an overflowing ADD: the set must win at capture.
    @(negedge clk);
    clr_sticky = 1'b1;
    cmd_opcode = 4'h0; cmd_a = 8'h7F; cmd_b = 8'h01;
    cmd_use_acc = 1'b0; cmd_wr_acc = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("clrset_cleared", sticky_ovf, 0);
    @(posedge clk); #1;
    chk("clrset_set_wins", sticky_ovf, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt++;
    chk("clrset_after", sticky_ovf, 0);
    chk("clrset_count", op_count, exp_cnt);
    clr_sticky = 1'b0;

    // Reset during ISSUE drops the command; acc was 0x01 before.
    @(negedge clk);
    cmd_opcode = 4'h0; cmd_a = 8'h01; cmd_b = 8'h01; cmd_wr_acc = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rstmid_in_issue", busy, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_acc", acc, ACC_RST);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstmid_no_rsp", rsp_valid, 0);
    end
    chk("rstmid_op_count", op_count, 0);
    chk("rstmid_acc_kept", acc, ACC_RST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
